cla_add_arbiter: RTL and testbench
==================================

// Module: cla_add_arbiter
// PURPOSE
//   Shares one registered WIDTH-bit carry-lookahead add pipeline among NREQ requesters.
//   - Round-robin arbiter selects one requester per cycle.
//   - Operands enter a 2-stage pipeline: operand register, then sum register.
//   - Results return on a single valid/ready response channel, tagged with the requester index.
//   - Sits between the CLAGenerator-based adder datapath and its client blocks.
// PARAMETERS
//   WIDTH  32  operand width; result is WIDTH+1 bits
//   NREQ   4   number of requesters, >=2 (need not be a power of 2)
//   IDW    2   requester-id width, = $clog2(NREQ)
// PORTS
//   clock      in   1           rising-edge clock
//   reset_n    in   1           asynchronous active-low reset
//   req_valid  in   NREQ        requester i presents operands
//   req_ready  out  NREQ        one-hot or zero; transfer when req_valid[i] & req_ready[i]
//   req_a      in   NREQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand B; same packing as req_a
//   req_cin    in   NREQ        carry-in of requester i
//   rsp_valid  out  1           result available
//   rsp_ready  in   1           consumer accepts result
//   rsp_id     out  IDW         index of requester owning the result
//   rsp_sum    out  WIDTH+1     {carry_out, sum}
//   busy       out  1           s1_valid | s2_valid
// BEHAVIOUR
//   Reset (reset_n low, async):
//   - s1_valid=0, s2_valid=0, ptr=0, rsp_sum=0, rsp_id=0.
//   - req_ready forced to 0 while reset_n is low.
//   - In-flight operations are discarded; no response is ever produced for them.
//   - reset_n deassertion is synchronised to clock upstream.
//   Stage S1 (operand regs a, b, cin, id, s1_valid):
//   - s1_adv  = s1_valid & (~s2_valid | rsp_ready)
//   - s1_load = ~s1_valid | s1_adv
//   Arbiter:
//   - g = first i with req_valid[i] = 1, scanning ptr, ptr+1, ... and wrapping NREQ-1 -> 0.
//   - req_ready[g] = s1_load; all other req_ready bits are 0.
//   - req_ready is combinational from req_valid and pipeline state; valid must not depend on ready.
//   - On transfer: S1 captures requester g, s1_valid=1, ptr <= (g==NREQ-1) ? 0 : g+1.
//   - No transfer: ptr holds. If s1_adv and no transfer, s1_valid <= 0.
//   Stage S2 (rsp regs):
//   - On s1_adv: rsp_sum <= a + b + cin at full WIDTH+1 width (carry-out in bit WIDTH, never
//     wrapped); rsp_id <= S1 id; s2_valid=1.
//   - On rsp handshake with no s1_adv: s2_valid <= 0.
//   - rsp_valid = s2_valid.
//   Latency and throughput:
//   - Transfer at edge k -> rsp_valid high after edge k+1 when unstalled, i.e. 2 clocks from
//     request to response.
//   - Throughput is 1 result/clock with rsp_ready held high.
//   Backpressure:
//   - While rsp_valid & ~rsp_ready: rsp_sum and rsp_id are stable, S1 holds.
//   - Once S1 is full, req_ready is all 0.
//   - No result is lost or duplicated.
//   Simultaneous handshake: a response accepted in the same cycle as s1_adv is immediately
//   replaced by the next result; no bubble is inserted.
//   Pipeline adder: instantiate CLAGenerator #(.WIDTH(WIDTH)) fed from the S1 registers.
// TESTING
//   T1 carry-out: req0 a=32'hFFFFFFFF b=1 cin=0, rsp_ready=1
//      -> rsp_valid 2 clocks later, rsp_sum=33'h1_00000000, rsp_id=0; busy low afterwards.
//   T2 carry-in: a=32'h7FFFFFFF b=0 cin=1 -> 33'h0_80000000;
//      a=b=32'hFFFFFFFF cin=1 -> 33'h1_FFFFFFFF.
//   T3 fairness: all 4 req_valid held high with distinct operands, rsp_ready=1
//      -> grants 0,1,2,3,0,1..., one per clock; rsp_id follows the same order with correct sums.
//   T4 rotation: grant to req2 (ptr=3), then req1 and req3 valid -> req3 granted first,
//      then req1; ptr ends at 2.
//   T5 backpressure: stream from req0/req1, rsp_ready low for 3 clocks
//      -> rsp_* stable, req_ready=0 after S1 fills; on release all results arrive in order,
//         none lost or duplicated.
//   T6 reset: reset_n pulsed low with both stages valid
//      -> rsp_valid=0 and req_ready=0 with no clock edge; after release req3-only is granted
//         first (ptr=0 scan), and no stale response appears.

Source files
------------

// File: rtl/cla_add_arbiter_if.sv
// Request/response bundle between adder clients and the shared CLA add pipeline.
// Requester i owns slice [i*WIDTH +: WIDTH] of req_a/req_b and bit i of the other request vectors.
interface cla_add_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH:0]        rsp_sum;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, busy
  );
endinterface

// File: rtl/cla_add_arbiter.sv
// Round-robin shared 2-stage carry-lookahead add pipeline: operand register, then sum register.
// Results are tagged with the owning requester index and returned on one valid/ready channel.

module CLAGenerator #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH:0]   o_sum
);
  localparam int unsigned NGrp = (WIDTH + 3) / 4;
  localparam int unsigned PW   = NGrp * 4;

  logic [PW-1:0] w_a;
  logic [PW-1:0] w_b;
  logic [PW-1:0] w_g;
  logic [PW-1:0] w_p;
  logic [PW:0]   w_c;
  logic [PW:0]   w_full;

  // 4-bit lookahead groups; zero padding above WIDTH turns the top carry into sum bit WIDTH.
  always_comb begin
    logic c0;
    w_a            = '0;
    w_b            = '0;
    w_a[WIDTH-1:0] = i_a;
    w_b[WIDTH-1:0] = i_b;
    w_g            = w_a & w_b;
    w_p            = w_a ^ w_b;
    w_c            = '0;
    w_c[0]         = i_cin;
    for (int j = 0; j < NGrp; j++) begin
      c0 = w_c[4*j];
      w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & c0);
      w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j]) | (w_p[4*j+1] & w_p[4*j] & c0);
      w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & c0);
      w_c[4*j+4] = w_g[4*j+3] | (w_p[4*j+3] & w_g[4*j+2])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & c0);
    end
    w_full = {w_c[PW], w_p ^ w_c[PW-1:0]};
  end

  assign o_sum = w_full[WIDTH:0];
endmodule

module cla_add_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  cla_add_arbiter_if.slave  bus
);
  localparam logic [IDW:0]   NreqW = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LastId = IDW'(NREQ - 1);

  logic [IDW-1:0] r_ptr;
  logic           r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic           r_cin;
  logic [IDW-1:0] r_s1_id;
  logic           r_s2_valid;
  logic [WIDTH:0] r_rsp_sum;
  logic [IDW-1:0] r_rsp_id;

  logic           w_s1_adv;
  logic           w_s1_load;
  logic           w_found;
  logic           w_xfer;
  logic [IDW:0]   w_idx;
  logic [IDW-1:0] w_gnt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic           w_cin;
  logic [WIDTH:0] w_sum;

  assign w_s1_adv  = r_s1_valid & (~r_s2_valid | bus.rsp_ready);
  assign w_s1_load = ~r_s1_valid | w_s1_adv;

  // First valid requester scanning upward from r_ptr, wrapping at NREQ (need not be 2**IDW).
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= NreqW) begin
        w_idx = w_idx - NreqW;
      end
      if (!w_found && bus.req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IDW-1:0];
      end
    end
  end

  // Gating with reset_n keeps req_ready low for the whole asynchronous reset window.
  assign w_xfer = w_found & w_s1_load & reset_n;

  always_comb begin
    bus.req_ready = '0;
    if (w_xfer) begin
      bus.req_ready[w_gnt] = 1'b1;
    end
  end

  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_a   = bus.req_a[i*WIDTH +: WIDTH];
        w_b   = bus.req_b[i*WIDTH +: WIDTH];
        w_cin = bus.req_cin[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_cin      <= 1'b0;
      r_s1_id    <= '0;
    end else if (w_xfer) begin
      r_ptr      <= (w_gnt == LastId) ? '0 : w_gnt + 1'b1;
      r_s1_valid <= 1'b1;
      r_a        <= w_a;
      r_b        <= w_b;
      r_cin      <= w_cin;
      r_s1_id    <= w_gnt;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  CLAGenerator #(
    .WIDTH(WIDTH)
  ) u_cla (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_cin(r_cin),
    .o_sum(w_sum)
  );

  // A response taken in the same cycle as s1_adv is replaced directly, so no bubble appears.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_rsp_sum  <= '0;
      r_rsp_id   <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_rsp_sum  <= w_sum;
      r_rsp_id   <= r_s1_id;
    end else if (r_s2_valid && bus.rsp_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_s2_valid;
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.busy      = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed bench for cla_add_arbiter: carry handling, round-robin order, backpressure and reset.
module tb_cla_add_arbiter;
  localparam int unsigned W = 32;
  localparam int unsigned N = 4;
  localparam int unsigned I = 2;

  logic clock = 1'b0;
  logic reset_n;
  int   checks;
  int   errors;

  always #5 clock = ~clock;

  cla_add_arbiter_if #(.WIDTH(W), .NREQ(N), .IDW(I)) bus ();

  cla_add_arbiter #(
    .WIDTH(W),
    .NREQ (N),
    .IDW  (I)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input int id, input logic [32:0] sum);
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, "_id"}, 64'(bus.rsp_id), 64'(id));
    chk({tag, "_sum"}, 64'(bus.rsp_sum), 64'(sum));
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
    bus.req_valid[i]      = 1'b1;
    bus.req_a[i*W +: W]   = a;
    bus.req_b[i*W +: W]   = b;
    bus.req_cin[i]        = cin;
  endtask

  task automatic drop(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int          t3_seq[5];
  logic [32:0] t3_sum[4];
  logic [3:0]  exp_rdy;

  initial begin
    checks        = 0;
    errors        = 0;
    t3_seq        = '{0, 1, 2, 3, 0};
    t3_sum        = '{33'h0_00000101, 33'h0_00000203, 33'h1_00000000, 33'h1_FFFFFFFE};
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with requests present.
    #2;
    bus.req_valid = 4'hF;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_sum", 64'(bus.rsp_sum), 64'h0);
    chk("rst_id", 64'(bus.rsp_id), 64'h0);
    bus.req_valid = '0;
    #4;
    reset_n = 1'b1;

    // T1 carry-out, 2-clock latency.
    set_req(0, 32'hFFFFFFFF, 32'h1, 1'b0);
    #1;
    chk("t1_ready", 64'(bus.req_ready), 64'h1);
    tick();
    drop(0);
    chk("t1_lat_valid", 64'(bus.rsp_valid), 64'h0);
    chk("t1_lat_busy", 64'(bus.busy), 64'h1);
    tick();
    chk_rsp("t1", 0, 33'h1_00000000);
    tick();
    chk("t1_idle_busy", 64'(bus.busy), 64'h0);
    chk("t1_idle_valid", 64'(bus.rsp_valid), 64'h0);

    // T2 carry-in (ptr=1, then 2).
    set_req(1, 32'h7FFFFFFF, 32'h0, 1'b1);
    #1;
    chk("t2_ready_a", 64'(bus.req_ready), 64'h2);
    tick();
    drop(1);
    set_req(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    #1;
    chk("t2_ready_b", 64'(bus.req_ready), 64'h4);
    tick();
    drop(2);
    chk_rsp("t2a", 1, 33'h0_80000000);
    tick();
    chk_rsp("t2b", 2, 33'h1_FFFFFFFF);
    tick();
    chk("t2_idle_busy", 64'(bus.busy), 64'h0);

    // Grant to the last requester wraps ptr back to 0.
    set_req(3, 32'h5, 32'h6, 1'b0);
    #1;
    chk("wrap_ready", 64'(bus.req_ready), 64'h8);
    tick();
    drop(3);
    tick();
    chk_rsp("wrap", 3, 33'h0_0000000B);
    tick();

    // T3 fairness: all requesters held valid.
    set_req(0, 32'h00000100, 32'h00000001, 1'b0);
    set_req(1, 32'h00000200, 32'h00000002, 1'b1);
    set_req(2, 32'hF0000000, 32'h10000000, 1'b0);
    set_req(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) begin
        bus.req_valid = '0;
      end
      if (c < 5) begin
        exp_rdy = 4'(1 << t3_seq[c]);
        chk($sformatf("t3_ready%0d", c), 64'(bus.req_ready), 64'(exp_rdy));
      end
      if (c >= 2) begin
        chk_rsp($sformatf("t3_rsp%0d", c), t3_seq[c-2], t3_sum[t3_seq[c-2]]);
      end
      tick();
    end
    chk("t3_idle_busy", 64'(bus.busy), 64'h0);
    chk("t3_idle_valid", 64'(bus.rsp_valid), 64'h0);

    // T4 rotation (ptr=1): req2 granted -> ptr=3, then req3 before req1, ptr ends at 2.
    set_req(2, 32'h1, 32'h2, 1'b0);
    #1;
    chk("t4_ready_r2", 64'(bus.req_ready), 64'h4);
    tick();
    drop(2);
    set_req(1, 32'h10, 32'h20, 1'b0);
    set_req(3, 32'hAAAAAAAA, 32'h55555555, 1'b1);
    #1;
    chk("t4_ready_r3", 64'(bus.req_ready), 64'h8);
    tick();
    drop(3);
    #1;
    chk("t4_ready_r1", 64'(bus.req_ready), 64'h2);
    chk_rsp("t4_r2", 2, 33'h0_00000003);
    tick();
    drop(1);
    chk_rsp("t4_r3", 3, 33'h1_00000000);
    set_req(1, 32'h1, 32'h1, 1'b0);
    set_req(2, 32'h7, 32'h8, 1'b0);
    #1;
    chk("t4_ptr2", 64'(bus.req_ready), 64'h4);
    tick();
    drop(2);
    #1;
    chk("t4_ready_r1b", 64'(bus.req_ready), 64'h2);
    chk_rsp("t4_r1a", 1, 33'h0_00000030);
    tick();
    drop(1);
    chk_rsp("t4_r2b", 2, 33'h0_0000000F);
    tick();
    chk_rsp("t4_r1b", 1, 33'h0_00000002);
    tick();
    chk("t4_idle_busy", 64'(bus.busy), 64'h0);

    // T5 backpressure (ptr=2): scan 2,3,0 grants req0 first.
    set_req(0, 32'h11111111, 32'h11111111, 1'b0);
    set_req(1, 32'h80000000, 32'h80000000, 1'b0);
    #1;
    chk("t5_ready0", 64'(bus.req_ready), 64'h1);
    tick();
    chk("t5_ready1", 64'(bus.req_ready), 64'h2);
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    chk_rsp("t5_stall", 0, 33'h0_22222222);
    chk("t5_stall_ready", 64'(bus.req_ready), 64'h0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_rsp($sformatf("t5_hold%0d", s), 0, 33'h0_22222222);
      chk($sformatf("t5_hold_ready%0d", s), 64'(bus.req_ready), 64'h0);
      chk($sformatf("t5_hold_busy%0d", s), 64'(bus.busy), 64'h1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t5_release_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    chk_rsp("t5_out1", 1, 33'h1_00000000);
    tick();
    chk_rsp("t5_out2", 0, 33'h0_22222222);
    tick();
    chk("t5_done_valid", 64'(bus.rsp_valid), 64'h0);
    chk("t5_done_busy", 64'(bus.busy), 64'h0);

    // T6 reset with both stages full (ptr=1).
    bus.rsp_ready = 1'b0;
    set_req(1, 32'h3, 32'h4, 1'b0);
    #1;
    chk("t6_fill_ready1", 64'(bus.req_ready), 64'h2);
    tick();
    drop(1);
    set_req(2, 32'h9, 32'h9, 1'b0);
    #1;
    chk("t6_fill_ready2", 64'(bus.req_ready), 64'h4);
    tick();
    drop(2);
    chk("t6_full_busy", 64'(bus.busy), 64'h1);
    chk("t6_full_valid", 64'(bus.rsp_valid), 64'h1);
    bus.req_valid = 4'hF;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.rsp_valid), 64'h0);
    chk("t6_rst_ready", 64'(bus.req_ready), 64'h0);
    chk("t6_rst_busy", 64'(bus.busy), 64'h0);
    chk("t6_rst_sum", 64'(bus.rsp_sum), 64'h0);
    #1;
    reset_n       = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    set_req(1, 32'h1, 32'h1, 1'b0);
    set_req(3, 32'h12345678, 32'h11111111, 1'b1);
    #1;
    chk("t6_ptr0", 64'(bus.req_ready), 64'h2);
    drop(1);
    #1;
    chk("t6_ready3", 64'(bus.req_ready), 64'h8);
    tick();
    drop(3);
    chk("t6_no_stale", 64'(bus.rsp_valid), 64'h0);
    tick();
    chk_rsp("t6", 3, 33'h0_2345678A);
    tick();
    chk("t6_end_valid", 64'(bus.rsp_valid), 64'h0);
    chk("t6_end_busy", 64'(bus.busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
